// File: rtl/ifmap_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : ifmap_stream_feeder
//  Purpose  : Streams a row-major ifmap from synchronous SRAM into the PE ifmap
//             FIFO, tagging EOR/EOF and packing PAR_WRITE lanes per word.
//  Revision : 1.0 - initial release
// ============================================================================
module ifmap_stream_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE  = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DIM_WIDTH  = 6
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic [DIM_WIDTH-1:0]                row_len,
    input  logic [DIM_WIDTH-1:0]                num_rows,
    output logic                                mem_ren,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    input  logic [DATA_WIDTH-1:0]               mem_rdata,
    input  logic                                ready_ifm,
    output logic                                w_en_ifm,
    output logic [(DATA_WIDTH+2)*PAR_WRITE-1:0] data_ifm,
    output logic                                busy,
    output logic                                done
);

    localparam int c_LANE_W = DATA_WIDTH + 2;
    localparam int c_CNT_W  = $clog2(PAR_WRITE + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CAPT  = 3'd2,
        S_PUSH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [DIM_WIDTH-1:0]  r_row_len;
    logic [DIM_WIDTH-1:0]  r_num_rows;
    logic [DIM_WIDTH-1:0]  r_row;
    logic [DIM_WIDTH-1:0]  r_col;
    logic [c_CNT_W-1:0]    r_rd_cnt;
    logic                  r_last;
    logic [c_LANE_W-1:0]   r_lane [PAR_WRITE];

    logic w_eor;
    logic w_eof;
    logic w_grp_end;

    // Flags describe the element being read this cycle
    assign w_eor     = (r_col == r_row_len - DIM_WIDTH'(1));
    assign w_eof     = w_eor && (r_row == r_num_rows - DIM_WIDTH'(1));
    assign w_grp_end = w_eof || (r_rd_cnt == c_CNT_W'(PAR_WRITE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_idx      <= '0;
            r_row_len  <= '0;
            r_num_rows <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_rd_cnt   <= '0;
            r_last     <= 1'b0;
            for (int j = 0; j < PAR_WRITE; j++) r_lane[j] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (row_len != '0 && num_rows != '0) begin
                            r_base     <= base_addr;
                            r_row_len  <= row_len;
                            r_num_rows <= num_rows;
                            r_idx      <= '0;
                            r_row      <= '0;
                            r_col      <= '0;
                            r_rd_cnt   <= '0;
                            r_last     <= 1'b0;
                            r_state    <= S_FETCH;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    // Flags are known at read time; pixel of the previous read lands now
                    for (int j = 0; j < PAR_WRITE; j++) begin
                        if (c_CNT_W'(j) == r_rd_cnt)
                            r_lane[j][DATA_WIDTH+1:DATA_WIDTH] <= {w_eof, w_eor};
                        if (c_CNT_W'(j + 1) == r_rd_cnt)
                            r_lane[j][DATA_WIDTH-1:0] <= mem_rdata;
                    end
                    r_rd_cnt <= r_rd_cnt + c_CNT_W'(1);
                    r_idx    <= r_idx + ADDR_WIDTH'(1);
                    if (w_eor) begin
                        r_col <= '0;
                        r_row <= r_row + DIM_WIDTH'(1);
                    end else begin
                        r_col <= r_col + DIM_WIDTH'(1);
                    end
                    if (w_eof)     r_last  <= 1'b1;
                    if (w_grp_end) r_state <= S_CAPT;
                end
                S_CAPT: begin
                    for (int j = 0; j < PAR_WRITE; j++) begin
                        if (c_CNT_W'(j + 1) == r_rd_cnt)
                            r_lane[j][DATA_WIDTH-1:0] <= mem_rdata;
                        else if (c_CNT_W'(j) >= r_rd_cnt)
                            r_lane[j] <= '0;
                    end
                    r_state <= S_PUSH;
                end
                S_PUSH: begin
                    if (ready_ifm) begin
                        r_rd_cnt <= '0;
                        r_state  <= r_last ? S_DONE : S_FETCH;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_ren  = (r_state == S_FETCH);
    assign mem_addr = r_base + r_idx;
    assign w_en_ifm = (r_state == S_PUSH) && ready_ifm;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

    for (genvar g = 0; g < PAR_WRITE; g++) begin : g_pack
        assign data_ifm[g*c_LANE_W +: c_LANE_W] = r_lane[g];
    end

endmodule
`default_nettype wire
